// File: rtl/melody_pkg.sv
// Shared constants for the melody player: note codes, half-period table, FSM states and song data.
// Song data lives here as a constant function so the ROM stays a plain synchronous lookup.
package melody_pkg;

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned DUR_W  = 4;
  localparam int unsigned HP_W   = 16;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_E5   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_G5   = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_A5   = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_B5   = 4'd12;
  localparam logic [NOTE_W-1:0] NOTE_C6   = 4'd13;
  localparam logic [NOTE_W-1:0] NOTE_D6   = 4'd14;
  localparam logic [NOTE_W-1:0] NOTE_E6   = 4'd15;

  // Half periods at 25 MHz: C5..B5 chromatic, then C6, D6, E6.
  localparam logic [HP_W-1:0] NOTE_HP [16] = '{
    16'd0,     16'd23889, 16'd22548, 16'd21282, 16'd20088, 16'd18960, 16'd17896, 16'd16892,
    16'd15943, 16'd15049, 16'd14204, 16'd13407, 16'd12654, 16'd11944, 16'd10641, 16'd9480
  };

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StPlay, StGap} state_e;

  function automatic logic [7:0] song_word(input logic [1:0] song, input int unsigned idx);
    logic [7:0] w;
    w = 8'h00;
    unique case (song)
      2'd0: case (idx)
        0: w = {NOTE_A5, 4'd2};
        1: w = {NOTE_REST, 4'd1};
        2: w = {NOTE_C5, 4'd1};
        default: w = 8'h00;
      endcase
      2'd1: case (idx)
        0, 1, 3: w = {NOTE_E6, 4'd1};
        2, 4:    w = {NOTE_REST, 4'd1};
        5:       w = {NOTE_C6, 4'd1};
        6:       w = {NOTE_E6, 4'd2};
        7:       w = {NOTE_G5, 4'd2};
        8:       w = {NOTE_REST, 4'd2};
        default: w = 8'h00;
      endcase
      2'd2: case (idx)
        0:       w = {NOTE_E6, 4'd2};
        1, 5:    w = {NOTE_B5, 4'd1};
        2, 4:    w = {NOTE_C6, 4'd1};
        3:       w = {NOTE_D6, 4'd2};
        6:       w = {NOTE_A5, 4'd2};
        7:       w = {NOTE_E5, 4'd1};
        default: w = 8'h00;
      endcase
      // No end marker: playback wraps after the last ROM entry.
      2'd3: w = {4'((idx % 15) + 1), 4'd1};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Synchronous song ROM, one-cycle read latency; four songs of SONG_LEN words each.
module melody_rom
  import melody_pkg::*;
#(
  parameter int unsigned SONG_LEN = 64,
  parameter int unsigned AW       = $clog2(SONG_LEN)
) (
  input  logic          clk,
  input  logic [1:0]    song_sel,
  input  logic [AW-1:0] addr,
  output logic [7:0]    data
);

  always_ff @(posedge clk) begin
    data <= song_word(song_sel, 32'(addr));
  end

endmodule

// File: rtl/melody_player.sv
// Plays one of four stored melodies as a square-wave tone; loops while enable is high.
// Each note: 2 fetch cycles, dur*TICK_CYCLES-GAP_CYCLES of tone, GAP_CYCLES of silence.
module melody_player
  import melody_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 1_562_500,
  parameter int unsigned GAP_CYCLES  = 125_000,
  parameter int unsigned SONG_LEN    = 64,
  parameter int unsigned HP_SHIFT    = 0,
  localparam int unsigned AW         = $clog2(SONG_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [1:0]    song_sel,
  output logic          tone,
  output logic          playing,
  output logic [AW-1:0] note_idx,
  output logic          loop_done
);

  localparam int unsigned CW = $clog2(15 * TICK_CYCLES + 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HP_W-1:0]   hp_q, hp_d, phase_q, phase_d;
  logic              tone_q, tone_d, rest_q, rest_d, loop_q, loop_d;
  logic [1:0]        song_q;
  logic [7:0]        rom_data;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign rom_note = rom_data[7:4];
  assign rom_dur  = rom_data[3:0];

  melody_rom #(.SONG_LEN(SONG_LEN), .AW(AW)) u_rom (
    .clk      (clk),
    .song_sel (song_sel),
    .addr     (idx_q),
    .data     (rom_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      hp_q    <= '0;
      phase_q <= '0;
      tone_q  <= 1'b0;
      rest_q  <= 1'b0;
      loop_q  <= 1'b0;
      song_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      phase_q <= phase_d;
      tone_q  <= tone_d;
      rest_q  <= rest_d;
      loop_q  <= loop_d;
      song_q  <= song_sel;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    phase_d = phase_q;
    tone_d  = tone_q;
    rest_d  = rest_q;
    loop_d  = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      idx_d   = '0;
      tone_d  = 1'b0;
    end else if (state_q != StIdle && song_sel != song_q) begin
      // New song: restart from its first entry without flagging a loop.
      state_d = StFetch;
      idx_d   = '0;
      tone_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StFetch;
          idx_d   = '0;
        end
        StFetch: state_d = StLatch;
        StLatch: begin
          if (rom_dur == '0) begin
            state_d = StFetch;
            idx_d   = '0;
            loop_d  = 1'b1;
          end else begin
            state_d = StPlay;
            hp_d    = NOTE_HP[rom_note] >> HP_SHIFT;
            rest_d  = (rom_note == NOTE_REST);
            phase_d = '0;
            tone_d  = 1'b0;
            cnt_d   = CW'(rom_dur) * CW'(TICK_CYCLES) - CW'(GAP_CYCLES);
          end
        end
        StPlay: begin
          if (phase_q == hp_q - HP_W'(1)) begin
            phase_d = '0;
            tone_d  = ~tone_q & ~rest_q;
          end else begin
            phase_d = phase_q + HP_W'(1);
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = StGap;
            tone_d  = 1'b0;
            cnt_d   = CW'(GAP_CYCLES);
          end
        end
        StGap: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = StFetch;
            if (idx_q == AW'(SONG_LEN - 1)) begin
              idx_d  = '0;
              loop_d = 1'b1;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    tone      = tone_q;
    playing   = (state_q != StIdle);
    note_idx  = idx_q;
    loop_done = loop_q;
  end

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: per-cycle comparison against a timeline model of the song data.
module tb_melody_player;
  import melody_pkg::song_word;

  localparam int unsigned TICK = 100;
  localparam int unsigned GAP  = 10;
  localparam int unsigned SLEN = 64;
  localparam int unsigned HPS  = 8;
  localparam int unsigned AW   = 6;
  // A5 hp = 14204>>8 = 55, 190 tone cycles: high for p in 55..109 and 165..189.
  localparam int unsigned A5_HIGH_CYCLES = 80;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [1:0]    song_sel;
  logic          tone, playing, loop_done;
  logic [AW-1:0] note_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int loop_cnt = 0;
  int hi_cnt   = 0;

  int unsigned tb_hp [16] = '{0, 23889, 22548, 21282, 20088, 18960, 17896, 16892,
                              15943, 15049, 14204, 13407, 12654, 11944, 10641, 9480};

  // Model: active flag, song, ROM index and cycle offset within the current note slot.
  bit          m_act, m_loop;
  logic [1:0]  m_song;
  int unsigned m_idx, m_off;

  melody_player #(
    .TICK_CYCLES (TICK),
    .GAP_CYCLES  (GAP),
    .SONG_LEN    (SLEN),
    .HP_SHIFT    (HPS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .song_sel  (song_sel),
    .tone      (tone),
    .playing   (playing),
    .note_idx  (note_idx),
    .loop_done (loop_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tone();
    logic [7:0]  w;
    int unsigned n, d, p, hp;
    if (!m_act || m_off < 2) return 1'b0;
    w = song_word(m_song, m_idx);
    n = 32'(w[7:4]);
    d = 32'(w[3:0]);
    if (d == 0 || n == 0) return 1'b0;
    p = m_off - 2;
    if (p >= d * TICK - GAP) return 1'b0;
    hp = tb_hp[n] >> HPS;
    return ((p / hp) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_act  = 1'b0;
    m_loop = 1'b0;
    m_idx  = 0;
    m_off  = 0;
    m_song = song_sel;
  endtask

  task automatic model_step(input logic en, input logic [1:0] ss);
    logic [7:0]  w;
    int unsigned len;
    m_loop = 1'b0;
    if (!en) begin
      m_act = 1'b0;
      m_idx = 0;
      m_off = 0;
    end else if (!m_act) begin
      m_act = 1'b1;
      m_idx = 0;
      m_off = 0;
    end else if (ss != m_song) begin
      m_idx = 0;
      m_off = 0;
    end else begin
      w   = song_word(m_song, m_idx);
      len = (w[3:0] == 4'd0) ? 2 : 2 + 32'(w[3:0]) * TICK;
      m_off++;
      if (m_off == len) begin
        m_off = 0;
        if (w[3:0] == 4'd0 || m_idx == SLEN - 1) begin
          m_idx  = 0;
          m_loop = 1'b1;
        end else begin
          m_idx++;
        end
      end
    end
    m_song = ss;
  endtask

  task automatic step();
    model_step(enable, song_sel);
    @(posedge clk);
    #1;
    check("tone", tone, exp_tone());
    check("playing", playing, m_act);
    check("note_idx", note_idx, m_idx);
    check("loop_done", loop_done, m_loop);
    if (loop_done) loop_cnt++;
    if (tone) hi_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    reset    = 1'b0;
    enable   = 1'b1;
    song_sel = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tone", tone, 0);
    check("rst_playing", playing, 0);
    check("rst_idx", note_idx, 0);
    check("rst_loop", loop_done, 0);
    reset = 1'b1;

    // Song 0: A5 x2, rest x1, C5 x1, marker; two full passes.
    loop_cnt = 0;
    hi_cnt   = 0;
    run(202);
    check("a5_high_cycles", hi_cnt, A5_HIGH_CYCLES);
    run(618);
    check("song0_loops", loop_cnt, 2);

    // Enable dropped mid-note, then re-enabled.
    run(100);
    enable = 1'b0;
    step();
    check("dis_tone", tone, 0);
    check("dis_idx", note_idx, 0);
    run(5);
    enable = 1'b1;
    run(300);

    // Song switch mid-note: restart at index 0 of the new song, no loop pulse.
    song_sel = 2'd1;
    run(150);
    song_sel = 2'd2;
    loop_cnt = 0;
    run(300);
    check("switch_no_loop", loop_cnt, 0);

    // Song without marker wraps after the last entry.
    song_sel = 2'd3;
    loop_cnt = 0;
    run(6540);
    check("wrap_loops", loop_cnt, 1);

    // Asynchronous reset while tone is high.
    song_sel = 2'd1;
    found    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (exp_tone()) begin
        found = 1'b1;
        break;
      end
    end
    check("found_high_tone", found, 1);
    #2 reset = 1'b0;
    #1;
    check("async_tone", tone, 0);
    check("async_playing", playing, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    for (int s = 0; s < 40; s++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      enable = (r >= 2);
      if (r >= 7) song_sel = 2'($urandom_range(0, 3));
      run(int'($urandom_range(1, 600)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
